bta_trunc_acc: RTL and testbench

BTA_TRUNC_ACC -- requirements
Module: bta_trunc_acc

---
 rtl/bta_trunc_pkg.sv | 13 +
 rtl/bta_trunc_core.sv | 19 +
 rtl/bta_trunc_acc.sv | 111 +++++++++++
 tb/tb_bta_trunc_acc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bta_trunc_pkg.sv
// Shared FSM state encoding and truncation-depth clamp for the truncated burst accumulator.
package bta_trunc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Requested depths above the synthesised maximum fall back to the maximum.
  function automatic int nab_clamp(input int nab, input int nab_max);
    return (nab > nab_max) ? nab_max : nab;
  endfunction

endpackage

// File: rtl/bta_trunc_core.sv
// Combinational adder that ignores the low n bits of both operands; carry is the
// carry out of the remaining upper field, and the low n bits of sum are always zero.
module bta_trunc_core #(
  parameter int BWOP = 10,
  parameter int NW   = 3
) (
  input  logic [BWOP-1:0] a,
  input  logic [BWOP-1:0] b,
  input  logic [NW-1:0]   n,
  output logic [BWOP-1:0] sum,
  output logic            carry
);

  logic [BWOP-1:0] mask;

  assign mask         = {BWOP{1'b1}} << n;
  assign {carry, sum} = {1'b0, a & mask} + {1'b0, b & mask};

endmodule

// File: rtl/bta_trunc_acc.sv
// Burst accumulator with runtime low-bit truncation; result valid one cycle after the last beat,
// held until out_ready. Build with BTA_TRUNC_ACC_SAT_EN to saturate instead of wrap on carry out.
module bta_trunc_acc
  import bta_trunc_pkg::*;
#(
  parameter int BWOP    = 10,
  parameter int NAB_MAX = 4,
  parameter int LEN_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NAB_MAX+1)-1:0] nab_cfg,
  input  logic [LEN_W-1:0]             len_cfg,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BWOP-1:0]              in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BWOP-1:0]              out_sum,
  output logic                         out_ovf,
  output logic                         busy
);

  localparam int NW = $clog2(NAB_MAX+1);

  logic [1:0]       state;
  logic [BWOP-1:0]  acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [NW-1:0]    n_q;
  logic             ovf;

  logic             accept;
  logic [NW-1:0]    n_first;
  logic [LEN_W-1:0] len_first;
  logic [LEN_W-1:0] cnt_nx;
  logic [BWOP-1:0]  add_a;
  logic [NW-1:0]    add_n;
  logic [BWOP-1:0]  add_sum;
  logic             add_carry;
  logic [BWOP-1:0]  sat_val;

  assign accept    = in_valid && in_ready;
  assign n_first   = NW'(nab_clamp(int'(nab_cfg), NAB_MAX));
  assign len_first = (len_cfg == '0) ? LEN_W'(1) : len_cfg;
  assign cnt_nx    = cnt + LEN_W'(1);
  assign sat_val   = {BWOP{1'b1}} << n_q;

  // The first beat reuses the adder with a zero addend, which yields the truncated load value.
  assign add_a = (state == ST_IDLE) ? '0 : acc;
  assign add_n = (state == ST_IDLE) ? n_first : n_q;

  bta_trunc_core #(
    .BWOP (BWOP),
    .NW   (NW)
  ) u_core (
    .a     (add_a),
    .b     (in_data),
    .n     (add_n),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready  = !rst && (state != ST_DONE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      n_q   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc   <= add_sum;
            n_q   <= n_first;
            len_q <= len_first;
            cnt   <= LEN_W'(1);
            ovf   <= 1'b0;
            state <= (len_first == LEN_W'(1)) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            cnt <= cnt_nx;
            ovf <= ovf | add_carry;
`ifdef BTA_TRUNC_ACC_SAT_EN
            // Once the burst has overflowed the accumulator stays pinned at the ceiling.
            acc <= (ovf || add_carry) ? sat_val : add_sum;
`else
            acc <= add_sum;
`endif
            if (cnt_nx == len_q) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bta_trunc_acc.sv
// Directed self-checking bench for bta_trunc_acc at BWOP=10, NAB_MAX=4.
module tb_bta_trunc_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] nab_cfg;
  logic [7:0] len_cfg;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_sum;
  logic       out_ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bta_trunc_acc #(.BWOP(10), .NAB_MAX(4), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .nab_cfg   (nab_cfg),
    .len_cfg   (len_cfg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] nab;
    logic [7:0] len;
    int         nb;
    logic [9:0] d0, d1, d2;
    logic [9:0] sum_wrap;
    logic [9:0] sum_sat;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one burst back to back from negedge to negedge, changing cfg after the first beat.
  task automatic run_burst(input string name, input logic [2:0] nab, input logic [7:0] len,
                           input int nb, input logic [9:0] d0, input logic [9:0] d1,
                           input logic [9:0] d2, input logic [9:0] exp_sum, input logic exp_ovf);
    logic [9:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    @(negedge clk);
    nab_cfg = nab;
    len_cfg = len;
    for (int i = 0; i < nb; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      check($sformatf("%s_in_ready%0d", name, i), 32'(in_ready), 32'd1);
      @(negedge clk);
      if (i == 0) begin
        nab_cfg = 3'd3;
        len_cfg = 8'd7;
      end
      if (i < nb - 1) begin
        check($sformatf("%s_early_valid%0d", name, i), 32'(out_valid), 32'd0);
        check($sformatf("%s_busy%0d", name, i), 32'(busy), 32'd1);
      end
    end
    in_valid = 1'b0;
    check({name, "_out_valid"}, 32'(out_valid), 32'd1);
    check({name, "_out_sum"},   32'(out_sum),   32'(exp_sum));
    check({name, "_out_ovf"},   32'(out_ovf),   32'(exp_ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_consumed"}, 32'(out_valid), 32'd0);
    check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic       saw_valid;
    logic [9:0] exp_sum;

    vecs[0] = '{nab:3'd2, len:8'd2, nb:2, d0:10'h007, d1:10'h00B, d2:10'h000, sum_wrap:10'h00C, sum_sat:10'h00C, ovf:1'b0};
    vecs[1] = '{nab:3'd0, len:8'd2, nb:2, d0:10'h3FF, d1:10'h001, d2:10'h000, sum_wrap:10'h000, sum_sat:10'h3FF, ovf:1'b1};
    vecs[2] = '{nab:3'd2, len:8'd2, nb:2, d0:10'h3FF, d1:10'h001, d2:10'h000, sum_wrap:10'h3FC, sum_sat:10'h3FC, ovf:1'b0};
    vecs[3] = '{nab:3'd2, len:8'd2, nb:2, d0:10'h3FF, d1:10'h004, d2:10'h000, sum_wrap:10'h000, sum_sat:10'h3FC, ovf:1'b1};
    vecs[4] = '{nab:3'd7, len:8'd0, nb:1, d0:10'h01F, d1:10'h000, d2:10'h000, sum_wrap:10'h010, sum_sat:10'h010, ovf:1'b0};
    vecs[5] = '{nab:3'd4, len:8'd1, nb:1, d0:10'h155, d1:10'h000, d2:10'h000, sum_wrap:10'h150, sum_sat:10'h150, ovf:1'b0};
    vecs[6] = '{nab:3'd0, len:8'd3, nb:3, d0:10'h100, d1:10'h200, d2:10'h0FF, sum_wrap:10'h3FF, sum_sat:10'h3FF, ovf:1'b0};
    vecs[7] = '{nab:3'd0, len:8'd3, nb:3, d0:10'h3FF, d1:10'h001, d2:10'h005, sum_wrap:10'h005, sum_sat:10'h3FF, ovf:1'b1};

    rst = 1'b1; nab_cfg = '0; len_cfg = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
`ifdef BTA_TRUNC_ACC_SAT_EN
      exp_sum = vecs[i].sum_sat;
`else
      exp_sum = vecs[i].sum_wrap;
`endif
      run_burst($sformatf("vec%0d", i), vecs[i].nab, vecs[i].len, vecs[i].nb,
                vecs[i].d0, vecs[i].d1, vecs[i].d2, exp_sum, vecs[i].ovf);
    end

    // Gapped beats, mid-burst cfg change and a stalled consumer.
    nab_cfg = 3'd1; len_cfg = 8'd3;
    in_valid = 1'b1; in_data = 10'h005;
    @(negedge clk);
    in_valid = 1'b0; nab_cfg = 3'd4; len_cfg = 8'd1;
    @(negedge clk);
    check("gap_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_data = 10'h003;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("gap_no_early_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 10'h009;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("stall_valid%0d", c),    32'(out_valid), 32'd1);
      check($sformatf("stall_sum%0d", c),      32'(out_sum),   32'h00E);
      check($sformatf("stall_ovf%0d", c),      32'(out_ovf),   32'd0);
      check($sformatf("stall_in_ready%0d", c), 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_consumed", 32'(out_valid), 32'd0);
    check("stall_idle",     32'(busy),      32'd0);

    // Reset in the middle of a burst throws the partial sum away.
    nab_cfg = 3'd0; len_cfg = 8'd3;
    in_valid = 1'b1; in_data = 10'h001;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",     32'(busy),     32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_sum",      32'(out_sum),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("mid_rst_no_result", 32'(saw_valid), 32'd0);
    check("mid_rst_ready",     32'(in_ready),  32'd1);
    run_burst("fresh", 3'd4, 8'd1, 1, 10'h155, 10'h000, 10'h000, 10'h150, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
